// File: rtl/riscv_pkg.sv
// riscv_pkg: shared funct3 encodings and memory-stage FSM states.
package riscv_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_t;
endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: picks the addressed byte/half of a read word and sign- or zero-extends it.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata_i[{off_i, 3'b000} +: 8];
  assign h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  // Unlisted funct3 encodings fall through to a full-word load.
  always_comb
    data_o = funct3_i == F3_LB  ? {{24{b[7]}}, b}  :
             funct3_i == F3_LBU ? {24'h0, b}       :
             funct3_i == F3_LH  ? {{16{h[15]}}, h} :
             funct3_i == F3_LHU ? {16'h0, h}       : rdata_i;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: drives the data-memory bus, stalls on wait states, and owns the MEM/WB register.
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ex_mem_valid,
  input  logic [XLEN-1:0] i_ex_mem_alu_result,
  input  logic [XLEN-1:0] i_ex_mem_store_data,
  input  logic [4:0]      i_ex_mem_rd,
  input  logic [2:0]      i_ex_mem_funct3,
  input  logic            i_ex_mem_reg_write,
  input  logic            i_ex_mem_mem_to_reg,
  input  logic            i_ex_mem_mem_read,
  input  logic            i_ex_mem_mem_write,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_wstrb,
  input  logic            i_dmem_ready,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_mem_stall,
  output logic [XLEN-1:0] o_mem_wb_read_data,
  output logic [XLEN-1:0] o_mem_wb_alu_result,
  output logic [4:0]      o_mem_wb_rd,
  output logic            o_mem_wb_reg_write,
  output logic            o_mem_wb_mem_to_reg,
  output logic            o_mem_misaligned
);
  mem_state_t state_q, state_d;
  logic mem_op, is_byte, is_half, misaligned;
  logic [1:0] off;
  logic [XLEN-1:0] load_data;
  assign off        = i_ex_mem_alu_result[1:0];
  assign is_byte    = i_ex_mem_funct3[1:0] == 2'b00;
  assign is_half    = i_ex_mem_funct3[1:0] == 2'b01;
  assign mem_op     = i_ex_mem_valid & (i_ex_mem_mem_read | i_ex_mem_mem_write);
  assign misaligned = mem_op & (is_half ? off[0] : ~is_byte & |off);
  // Gating with reset drops an outstanding request immediately when reset hits mid-access.
  assign o_dmem_req   = i_rst_n & mem_op & ~misaligned;
  assign o_dmem_we    = i_ex_mem_mem_write;
  assign o_dmem_addr  = {i_ex_mem_alu_result[XLEN-1:2], 2'b00};
  assign o_dmem_wdata = is_byte ? {4{i_ex_mem_store_data[7:0]}} :
                        is_half ? {2{i_ex_mem_store_data[15:0]}} : i_ex_mem_store_data;
  assign o_dmem_wstrb = ~i_ex_mem_mem_write ? 4'b0000 :
                        is_byte ? 4'b0001 << off :
                        is_half ? 4'b0011 << off : 4'b1111;
  assign o_mem_stall  = o_dmem_req & ~i_dmem_ready;
  load_align u_align (
    .rdata_i (i_dmem_rdata),
    .off_i   (off),
    .funct3_i(i_ex_mem_funct3),
    .data_o  (load_data)
  );
  always_comb
    state_d = state_q == MEM_IDLE ? (o_mem_stall ? MEM_WAIT : MEM_IDLE)
                                  : (i_dmem_ready ? MEM_IDLE : MEM_WAIT);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q             <= MEM_IDLE;
      o_mem_wb_read_data  <= '0;
      o_mem_wb_alu_result <= '0;
      o_mem_wb_rd         <= '0;
      o_mem_wb_reg_write  <= 1'b0;
      o_mem_wb_mem_to_reg <= 1'b0;
      o_mem_misaligned    <= 1'b0;
    end else begin
      state_q          <= state_d;
      o_mem_misaligned <= misaligned;
      if (o_mem_stall) begin
        o_mem_wb_reg_write <= 1'b0;
      end else begin
        o_mem_wb_read_data  <= (i_ex_mem_valid & i_ex_mem_mem_read & ~misaligned) ? load_data : '0;
        o_mem_wb_alu_result <= i_ex_mem_alu_result;
        o_mem_wb_rd         <= i_ex_mem_rd;
        o_mem_wb_reg_write  <= i_ex_mem_reg_write & i_ex_mem_valid & ~misaligned;
        o_mem_wb_mem_to_reg <= i_ex_mem_mem_to_reg;
      end
    end
  end
endmodule
